alien_formation: RTL and testbench
==================================

ALIEN_FORMATION -- requirements
Module: alien_formation

Interface
REQ-001 Parameter COLS, 8, number of alien columns.
REQ-002 Parameter ROWS, 4, number of alien rows.
REQ-003 Parameter STEP_DIV, 8, enable ticks per formation move (1..255).
REQ-004 clk_36MHz  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 enable  in  1  game tick strobe, one cycle wide.
REQ-007 start  in  1  debounced start pulse from the player stage.
REQ-008 clear  in  1  return to IDLE from any state.
REQ-009 bullet_x  in  5  player bullet column.
REQ-010 bullet_y  in  4  player bullet row.
REQ-011 bullet_flying  in  1  bullet position is valid.
REQ-012 hit  out  1  one-cycle pulse, one alien destroyed; drives the player hit input.
REQ-013 alien_map  out  COLS*ROWS  alive bits; bit r*COLS+c is row r, column c.
REQ-014 formation_x  out  5  screen column of column-0 aliens.
REQ-015 formation_y  out  4  screen row of row-0 aliens.
REQ-016 state  out  2  IDLE=0, PLAY=1, WON=2, LOST=3.

Function
REQ-017 Alien (r,c) SHALL occupy screen x = formation_x + 2c, y = formation_y + r.
REQ-018 IDLE: alien_map all ones, formation at (0,0), direction right, tick counter 0; start=1 -> PLAY.
REQ-019 PLAY: tick counter increments on enable; at STEP_DIV-1 it wraps to 0 and the formation moves one step.
REQ-020 Move right: formation_x+1 while formation_x < 32-2*COLS; at that limit, formation_y+1 and direction flips to left instead.
REQ-021 Move left: formation_x-1 while formation_x > 0; at 0, formation_y+1 and direction flips to right instead.
REQ-022 Collision in PLAY only: bullet_flying=1, dx=bullet_x-formation_x in 0..2COLS-1 and even, dy=bullet_y-formation_y in 0..ROWS-1, alien (dy,dx/2) alive.
REQ-023 On collision, hit SHALL be 1 in the next cycle and the alien bit cleared on the same edge; hit otherwise 0.
REQ-024 A bullet still flying in the cycle after a hit SHALL NOT produce a second hit (bit already cleared).
REQ-025 Collision SHALL be evaluated against the pre-move position when a move occurs in the same cycle; both take effect.
REQ-026 PLAY -> WON on the cycle after alien_map becomes zero.
REQ-027 PLAY -> LOST when a move makes formation_y + ROWS-1 >= 14.
REQ-028 Last kill and landing in the same cycle: WON SHALL take priority.
REQ-029 WON and LOST hold all outputs until clear=1 -> IDLE; start ignored there.
REQ-030 clear=1 in any state SHALL force IDLE next cycle, overriding start, enable, collision.
REQ-031 Coordinate arithmetic SHALL be unsigned with explicit range checks; no wrap-around positions produced.

Reset
REQ-032 reset=0 SHALL force IDLE, alien_map all ones, formation (0,0), direction right, tick counter 0, hit 0, regardless of other inputs.
REQ-033 Reset mid-PLAY SHALL discard any pending hit.
REQ-034 The block SHALL also initialise to the reset values at configuration.

Structure
REQ-035 Shared package holds the state encoding, SCREEN_COLS=32, LANDING_ROW=14.
REQ-036 One sub-module, alien_hit_detect: combinational collision decode returning hit_valid and alien index.
REQ-037 Moving/counting and state machine remain in alien_formation.

Verification
REQ-038 Reset, start pulse -> state=1, alien_map=0xFFFFFFFF, formation (0,0).
REQ-039 8 enables (STEP_DIV=8) -> formation_x=1; 128 enables -> formation_x=16; next 8 -> formation_y=1, formation_x=16, then decreasing.
REQ-040 Formation (0,0), bullet (4,2) flying -> hit one cycle later, bit 18 cleared, no hit next cycle with bullet unchanged.
REQ-041 Bullet (3,0) flying -> no hit (odd dx); bullet (16,0) -> no hit (dx out of range).
REQ-042 Kill all 32 aliens -> state=2; clear -> state=0, map restored.
REQ-043 No shots, keep ticking -> state=3 when formation_y reaches 11; reset=0 mid-PLAY -> IDLE values.

Source files
------------

// File: rtl/alien_formation_pkg.sv
// Shared definitions for the alien formation block: state encoding and
// playfield geometry.
package alien_formation_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      WON  = 2'd2,
      LOST = 2'd3
   } state_t;

   localparam int SCREEN_COLS = 32;
   localparam int LANDING_ROW = 14;

endpackage

// File: rtl/alien_hit_detect.sv
// Combinational bullet/alien collision decode. Aliens sit on even screen
// columns, so an odd column offset never hits.
module alien_hit_detect
   import alien_formation_pkg::*;
#(
   parameter  int COLS = 8,
   parameter  int ROWS = 4,
   localparam int NA   = COLS * ROWS,
   localparam int IW   = (NA > 1) ? $clog2(NA) : 1
) (
   input  logic [4:0]    bullet_x,
   input  logic [3:0]    bullet_y,
   input  logic          bullet_flying,
   input  logic [4:0]    formation_x,
   input  logic [3:0]    formation_y,
   input  logic [NA-1:0] alien_map,
   output logic          hit_valid,
   output logic [IW-1:0] alien_idx
);

   logic [4:0]    dx;
   logic [3:0]    dy;
   logic          in_x;
   logic          in_y;
   logic [IW-1:0] idx;

   always_comb begin
      dx   = bullet_x - formation_x;
      dy   = bullet_y - formation_y;
      // Ordering checks first so a bullet left of / above the formation
      // never aliases through the unsigned subtraction.
      in_x = (bullet_x >= formation_x) && (int'(dx) < 2 * COLS) && !dx[0];
      in_y = (bullet_y >= formation_y) && (int'(dy) < ROWS);
      idx  = IW'(int'(dy) * COLS + int'(dx >> 1));
      hit_valid = bullet_flying && in_x && in_y && alien_map[idx];
      alien_idx = idx;
   end

endmodule

// File: rtl/alien_formation.sv
// Alien formation: march timing, edge bounce/descent, kill bookkeeping and
// the IDLE/PLAY/WON/LOST game state.
module alien_formation
   import alien_formation_pkg::*;
#(
   parameter int COLS     = 8,
   parameter int ROWS     = 4,
   parameter int STEP_DIV = 8
) (
   input  logic                 clk_36MHz,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 start,
   input  logic                 clear,
   input  logic [4:0]           bullet_x,
   input  logic [3:0]           bullet_y,
   input  logic                 bullet_flying,
   output logic                 hit,
   output logic [COLS*ROWS-1:0] alien_map,
   output logic [4:0]           formation_x,
   output logic [3:0]           formation_y,
   output logic [1:0]           state
);

   localparam int         NA    = COLS * ROWS;
   localparam int         IW    = (NA > 1) ? $clog2(NA) : 1;
   localparam logic [4:0] X_MAX = 5'(SCREEN_COLS - 2 * COLS);
   localparam logic [7:0] T_MAX = 8'(STEP_DIV - 1);

   // Declaration values give the power-up state on configuration.
   state_t          state_q  = IDLE;
   logic [NA-1:0]   map_q    = '1;
   logic [4:0]      fx_q     = '0;
   logic [3:0]      fy_q     = '0;
   logic            left_q   = 1'b0;
   logic [7:0]      tick_q   = '0;
   logic            hit_q    = 1'b0;

   state_t          state_d;
   logic [NA-1:0]   map_d;
   logic [4:0]      fx_d;
   logic [3:0]      fy_d;
   logic            left_d;
   logic [7:0]      tick_d;
   logic            hit_d;
   logic            move;
   logic            landed;
   logic            hit_valid;
   logic [IW-1:0]   alien_idx;

   alien_hit_detect #(.COLS(COLS), .ROWS(ROWS)) u_hit_detect (
      .bullet_x      (bullet_x),
      .bullet_y      (bullet_y),
      .bullet_flying (bullet_flying),
      .formation_x   (fx_q),
      .formation_y   (fy_q),
      .alien_map     (map_q),
      .hit_valid     (hit_valid),
      .alien_idx     (alien_idx)
   );

   always_comb begin
      state_d = state_q;
      map_d   = map_q;
      fx_d    = fx_q;
      fy_d    = fy_q;
      left_d  = left_q;
      tick_d  = tick_q;
      hit_d   = 1'b0;
      move    = 1'b0;
      landed  = (int'(fy_q) + ROWS - 1) >= LANDING_ROW;

      case (state_q)
         IDLE: if (start) state_d = PLAY;
         PLAY: begin
            // Collision uses the pre-move position; both effects land together.
            if (hit_valid) begin
               hit_d            = 1'b1;
               map_d[alien_idx] = 1'b0;
            end
            if (enable) begin
               if (tick_q == T_MAX) begin
                  tick_d = '0;
                  move   = 1'b1;
               end else begin
                  tick_d = tick_q + 8'd1;
               end
            end
            if (move) begin
               if (!left_q && fx_q < X_MAX)
                  fx_d = fx_q + 5'd1;
               else if (left_q && fx_q != 5'd0)
                  fx_d = fx_q - 5'd1;
               else begin
                  if (fy_q != 4'd15) fy_d = fy_q + 4'd1;
                  left_d = !left_q;
               end
            end
            if (map_q == '0)
               state_d = WON;
            else if (landed)
               state_d = LOST;
         end
         default: ;
      endcase

      if (clear) begin
         state_d = IDLE;
         map_d   = '1;
         fx_d    = '0;
         fy_d    = '0;
         left_d  = 1'b0;
         tick_d  = '0;
         hit_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_36MHz) begin
      if (!reset) begin
         state_q <= IDLE;
         map_q   <= '1;
         fx_q    <= '0;
         fy_q    <= '0;
         left_q  <= 1'b0;
         tick_q  <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         map_q   <= map_d;
         fx_q    <= fx_d;
         fy_q    <= fy_d;
         left_q  <= left_d;
         tick_q  <= tick_d;
         hit_q   <= hit_d;
      end
   end

   assign hit         = hit_q;
   assign alien_map   = map_q;
   assign formation_x = fx_q;
   assign formation_y = fy_q;
   assign state       = state_q;

endmodule

// File: tb/tb_alien_formation.sv
// Directed bench for alien_formation with a screen-coordinate reference model
// checked every cycle plus literal spot checks.
module tb_alien_formation;

   localparam int COLS = 8, ROWS = 4, STEP_DIV = 8;

   logic        clk_36MHz = 1'b0;
   logic        reset = 1'b0, enable = 1'b0, start = 1'b0, clear = 1'b0;
   logic        bullet_flying = 1'b0;
   logic [4:0]  bullet_x = '0;
   logic [3:0]  bullet_y = '0;
   logic        hit;
   logic [31:0] alien_map;
   logic [4:0]  formation_x;
   logic [3:0]  formation_y;
   logic [1:0]  state;

   int n_checks = 0, n_fail = 0;
   bit cmp_on = 1'b0;

   always #14 clk_36MHz = ~clk_36MHz;

   alien_formation #(.COLS(COLS), .ROWS(ROWS), .STEP_DIV(STEP_DIV)) dut (
      .clk_36MHz     (clk_36MHz),
      .reset         (reset),
      .enable        (enable),
      .start         (start),
      .clear         (clear),
      .bullet_x      (bullet_x),
      .bullet_y      (bullet_y),
      .bullet_flying (bullet_flying),
      .hit           (hit),
      .alien_map     (alien_map),
      .formation_x   (formation_x),
      .formation_y   (formation_y),
      .state         (state)
   );

   // Reference model: aliens as a 2-D alive grid, positions as plain integers.
   bit m_alive[ROWS][COLS];
   int m_fx, m_fy, m_ticks, m_st;
   bit m_left, m_hit;

   function automatic logic [31:0] m_map();
      logic [31:0] v = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            v[r*COLS+c] = m_alive[r][c];
      return v;
   endfunction

   task automatic m_idle();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            m_alive[r][c] = 1'b1;
      m_fx = 0; m_fy = 0; m_left = 1'b0; m_ticks = 0; m_st = 0; m_hit = 1'b0;
   endtask

   always @(posedge clk_36MHz) begin
      int kr, kc;
      bit any_alive, landed;
      if (!reset || clear) m_idle();
      else begin
         m_hit = 1'b0;
         if (m_st == 0) begin
            if (start) m_st = 1;
         end else if (m_st == 1) begin
            any_alive = 1'b0; kr = -1; kc = -1;
            for (int r = 0; r < ROWS; r++)
               for (int c = 0; c < COLS; c++)
                  if (m_alive[r][c]) begin
                     any_alive = 1'b1;
                     if (bullet_flying && int'(bullet_x) == m_fx + 2*c &&
                         int'(bullet_y) == m_fy + r) begin
                        kr = r; kc = c;
                     end
                  end
            landed = (m_fy + ROWS - 1 >= 14);
            if (kr >= 0) begin m_hit = 1'b1; m_alive[kr][kc] = 1'b0; end
            if (!any_alive) m_st = 2;
            else if (landed) m_st = 3;
            if (enable) begin
               m_ticks++;
               if (m_ticks == STEP_DIV) begin
                  m_ticks = 0;
                  if (!m_left && m_fx + 2*COLS < 32) m_fx++;
                  else if (m_left && m_fx > 0) m_fx--;
                  else begin m_fy++; m_left = !m_left; end
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_36MHz) if (cmp_on) begin
      check("model_state", 32'(state), 32'(m_st));
      check("model_map", alien_map, m_map());
      check("model_fx", 32'(formation_x), 32'(m_fx));
      check("model_fy", 32'(formation_y), 32'(m_fy));
      check("model_hit", 32'(hit), 32'(m_hit));
   end

   task automatic cyc();
      @(posedge clk_36MHz); #1;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         enable = 1'b1; cyc();
         enable = 1'b0; cyc();
      end
   endtask

   task automatic restart();
      clear = 1'b1; cyc(); clear = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   initial begin
      repeat (3) cyc();
      cmp_on = 1'b1;
      @(negedge clk_36MHz);
      check("reset_state", 32'(state), 32'd0);
      check("reset_map", alien_map, 32'hFFFF_FFFF);
      check("reset_pos", {formation_x, formation_y}, 32'd0);
      check("reset_hit", 32'(hit), 32'd0);

      reset = 1'b1; cyc();
      start = 1'b1; cyc(); start = 1'b0;
      @(negedge clk_36MHz);
      check("start_state", 32'(state), 32'd1);
      check("start_map", alien_map, 32'hFFFF_FFFF);

      tick(8);   @(negedge clk_36MHz); check("fx_after_8", 32'(formation_x), 32'd1);
      tick(120); @(negedge clk_36MHz); check("fx_after_128", 32'(formation_x), 32'd16);
      tick(8);   @(negedge clk_36MHz); check("edge_fy", 32'(formation_y), 32'd1);
                                       check("edge_fx", 32'(formation_x), 32'd16);
      tick(8);   @(negedge clk_36MHz); check("left_fx", 32'(formation_x), 32'd15);

      // Single kill at (4,2) -> alien row 2 col 2, bit 18; no double hit
      restart();
      bullet_x = 5'd4; bullet_y = 4'd2; bullet_flying = 1'b1; cyc();
      @(negedge clk_36MHz);
      check("hit_pulse", 32'(hit), 32'd1);
      check("hit_map", alien_map, 32'hFFFB_FFFF);
      cyc(); @(negedge clk_36MHz);
      check("no_double_hit", 32'(hit), 32'd0);

      bullet_x = 5'd3; bullet_y = 4'd0; cyc(); @(negedge clk_36MHz);
      check("odd_dx", 32'(hit), 32'd0);
      bullet_x = 5'd16; cyc(); @(negedge clk_36MHz);
      check("dx_range", 32'(hit), 32'd0);
      check("dx_range_map", alien_map, 32'hFFFB_FFFF);
      bullet_x = 5'd0; bullet_flying = 1'b0; cyc();

      // Hit and move on the same edge: alien (0,0) hit at pre-move x
      tick(7);
      enable = 1'b1; bullet_x = 5'd0; bullet_y = 4'd0; bullet_flying = 1'b1; cyc();
      enable = 1'b0; bullet_flying = 1'b0;
      @(negedge clk_36MHz);
      check("move_hit", 32'(hit), 32'd1);
      check("move_hit_fx", 32'(formation_x), 32'd1);
      check("move_hit_map", alien_map, 32'hFFFB_FFFE);

      // Kill the rest with formation at (1,0)
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            bullet_x = 5'(1 + 2*c); bullet_y = 4'(r); bullet_flying = 1'b1; cyc();
         end
      bullet_flying = 1'b0; cyc();
      @(negedge clk_36MHz);
      check("won_state", 32'(state), 32'd2);
      check("won_map", alien_map, 32'd0);
      start = 1'b1; cyc(); start = 1'b0;
      @(negedge clk_36MHz); check("won_ignore_start", 32'(state), 32'd2);
      clear = 1'b1; start = 1'b1; cyc(); clear = 1'b0;
      @(negedge clk_36MHz);
      check("clear_state", 32'(state), 32'd0);
      check("clear_map", alien_map, 32'hFFFF_FFFF);
      clear = 1'b1; cyc(); clear = 1'b0; start = 1'b0;
      @(negedge clk_36MHz); check("clear_over_start", 32'(state), 32'd0);

      // March to the landing row: 187 moves reach formation_y = 11
      start = 1'b1; cyc(); start = 1'b0;
      tick(187 * STEP_DIV);
      @(negedge clk_36MHz);
      check("lost_state", 32'(state), 32'd3);
      check("lost_fy", 32'(formation_y), 32'd11);
      check("lost_fx", 32'(formation_x), 32'd16);
      tick(8);
      start = 1'b1; cyc(); start = 1'b0;
      @(negedge clk_36MHz);
      check("lost_hold_state", 32'(state), 32'd3);
      check("lost_hold_fx", 32'(formation_x), 32'd16);

      // Reset mid-play with a collision pending
      restart();
      tick(8);
      bullet_x = 5'd1; bullet_y = 4'd0; bullet_flying = 1'b1; reset = 1'b0; cyc();
      reset = 1'b1; bullet_flying = 1'b0;
      @(negedge clk_36MHz);
      check("rst_hit", 32'(hit), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_map", alien_map, 32'hFFFF_FFFF);
      check("rst_fx", 32'(formation_x), 32'd0);
      cyc(); cyc();

      cmp_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
